// File: rtl/game_io_pkg.sv
// -----------------------------------------------------------------------------
// game_io_pkg
// Shared types and constants for the game I/O interrupt arbiter.
//   src_id_t     : interrupt source identifier (NONE/FRAME/JUMP/EXT)
//   arb_state_t  : arbiter FSM states (IDLE/ISSUE/HOLDOFF)
//   JAL_OPCODE   : opcode field of the jump-and-link handed to the CPU
//   NOP_INSTR    : instruction driven whenever no interrupt is being issued
//   pick_src()   : fixed-priority selector, frame > jump > ext
// Optional feature macro used by the top: INT_ARB_MASK_EN.
// -----------------------------------------------------------------------------
package game_io_pkg;

   typedef enum logic [1:0] {
      SRC_NONE  = 2'd0,
      SRC_FRAME = 2'd1,
      SRC_JUMP  = 2'd2,
      SRC_EXT   = 2'd3
   } src_id_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_HOLDOFF = 2'd2
   } arb_state_t;

   localparam logic [4:0]  JAL_OPCODE = 5'b00011;
   localparam logic [31:0] NOP_INSTR  = 32'd0;

   // Bit 0 = frame, bit 1 = jump, bit 2 = ext; lower bit wins.
   function automatic src_id_t pick_src(input logic [2:0] eligible);
      if (eligible[0])      return SRC_FRAME;
      else if (eligible[1]) return SRC_JUMP;
      else if (eligible[2]) return SRC_EXT;
      else                  return SRC_NONE;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
// Brings an asynchronous level into the clock domain, optionally debounces it,
// and emits a one-cycle rising-edge indication of the resulting level.
//   clock   in  : system clock
//   reset   in  : asynchronous, active-low
//   i_async in  : raw asynchronous input
//   o_rise  out : high for one cycle after the (debounced) level goes 0->1
// DEBOUNCE_CYCLES = 0 bypasses the debouncer (level = second sync flop).
// Otherwise the debounced level follows the synchronized input only after the
// two have differed for DEBOUNCE_CYCLES consecutive clocks.
// -----------------------------------------------------------------------------
module sync_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic i_async,
   output logic o_rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic w_db;

   // NOTE: all sequential state uses non-blocking assignments so every flop
   // samples pre-edge values; blocking here would collapse the sync chain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
         r_prev  <= w_db;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign w_db = r_sync2;
      end else begin : g_debounce
         logic [15:0] r_cnt;
         logic        r_db;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               r_cnt <= 16'd0;
               r_db  <= 1'b0;
            end else if (r_sync2 != r_db) begin
               if (r_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                  r_db  <= r_sync2;
                  r_cnt <= 16'd0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end else begin
               // Any agreeing cycle restarts the stability window.
               r_cnt <= 16'd0;
            end
         end

         assign w_db = r_db;
      end
   endgenerate

   assign o_rise = w_db & ~r_prev;

endmodule

// File: rtl/interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// interrupt_arbiter
// Latches game events as pending interrupts, issues one at a time to the CPU
// as a jump-and-link to the source's handler, and enforces a hold-off window
// after every acknowledge.
//   clock                 in  : system clock
//   reset                 in  : asynchronous, active-low
//   frame_tick            in  : async frame clock; each rising edge = event
//   jump_key              in  : async push button; debounced rising edge = event
//   ext_req               in  : synchronous single-cycle request pulse
//   instr_ack             in  : CPU accepted interrupt_instruction this cycle
//   irq_mask[2:0]         in  : only with INT_ARB_MASK_EN; 1 = source masked
//   interrupt_instruction out : {JAL_OPCODE, vector} while issuing, else 0
//   instr_valid           out : high exactly while in ISSUE
//   active_src            out : 0 none, 1 frame, 2 jump, 3 ext
//   drop_count            out : saturating count of events lost to a busy slot
// Optional feature macro: INT_ARB_MASK_EN (adds irq_mask input).
// -----------------------------------------------------------------------------
module interrupt_arbiter
   import game_io_pkg::*;
#(
   parameter logic [26:0] FRAME_VEC       = 27'd100,
   parameter logic [26:0] JUMP_VEC        = 27'd200,
   parameter logic [26:0] EXT_VEC         = 27'd300,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLDOFF_CYCLES  = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        jump_key,
   input  logic        ext_req,
   input  logic        instr_ack,
`ifdef INT_ARB_MASK_EN
   input  logic [2:0]  irq_mask,
`endif
   output logic [31:0] interrupt_instruction,
   output logic        instr_valid,
   output logic [1:0]  active_src,
   output logic [7:0]  drop_count
);

   logic [2:0]  w_rise;
   logic [2:0]  w_clear;
   logic [2:0]  w_drop;
   logic [2:0]  w_elig;
   logic [1:0]  w_drop_n;
   logic [8:0]  w_drop_sum;
   src_id_t     w_sel;
   logic [26:0] w_vec;

   logic [2:0]  r_pend;
   logic [7:0]  r_drop;
   arb_state_t  r_state;
   src_id_t     r_active;
   logic [31:0] r_instr;
   logic        r_valid;
   logic [15:0] r_hold;

   sync_debounce #(.DEBOUNCE_CYCLES(0)) u_frame (
      .clock   (clock),
      .reset   (reset),
      .i_async (frame_tick),
      .o_rise  (w_rise[0])
   );

   sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump (
      .clock   (clock),
      .reset   (reset),
      .i_async (jump_key),
      .o_rise  (w_rise[1])
   );

   assign w_rise[2] = ext_req;

   // NOTE: every variable written in always_comb gets a default first so no
   // path leaves it unassigned (which would infer a latch).
   always_comb begin
      w_clear = 3'b000;
      if (r_state == ST_ISSUE && instr_ack) begin
         case (r_active)
            SRC_FRAME: w_clear = 3'b001;
            SRC_JUMP:  w_clear = 3'b010;
            SRC_EXT:   w_clear = 3'b100;
            default:   w_clear = 3'b000;
         endcase
      end
   end

`ifdef INT_ARB_MASK_EN
   // Masked sources keep their pending bit; clearing the mask releases it.
   assign w_elig = r_pend & ~irq_mask;
`else
   assign w_elig = r_pend;
`endif

   assign w_sel = pick_src(w_elig);

   always_comb begin
      w_vec = 27'd0;
      case (w_sel)
         SRC_FRAME: w_vec = FRAME_VEC;
         SRC_JUMP:  w_vec = JUMP_VEC;
         SRC_EXT:   w_vec = EXT_VEC;
         default:   w_vec = 27'd0;
      endcase
   end

   // An edge coinciding with its own clear re-pends (kept); an edge hitting a
   // pending bit that is not clearing is lost.
   assign w_drop     = w_rise & r_pend & ~w_clear;
   assign w_drop_n   = {1'b0, w_drop[0]} + {1'b0, w_drop[1]} + {1'b0, w_drop[2]};
   assign w_drop_sum = {1'b0, r_drop} + {7'd0, w_drop_n};

   // NOTE: every flop here, counters included, is cleared by reset; there is
   // no memory array whose contents could be left unreset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pend <= 3'b000;
         r_drop <= 8'd0;
      end else begin
         r_pend <= (r_pend & ~w_clear) | w_rise;
         r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_active <= SRC_NONE;
         r_instr  <= NOP_INSTR;
         r_valid  <= 1'b0;
         r_hold   <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_elig) begin
                  r_active <= w_sel;
                  r_instr  <= {JAL_OPCODE, w_vec};
                  r_valid  <= 1'b1;
                  r_state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Instruction and source stay frozen until the CPU accepts.
               if (instr_ack) begin
                  r_active <= SRC_NONE;
                  r_instr  <= NOP_INSTR;
                  r_valid  <= 1'b0;
                  if (HOLDOFF_CYCLES == 0) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_HOLDOFF;
                     r_hold  <= 16'(HOLDOFF_CYCLES);
                  end
               end
            end
            ST_HOLDOFF: begin
               r_hold <= r_hold - 16'd1;
               if (r_hold == 16'd1) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign interrupt_instruction = r_instr;
   assign instr_valid           = r_valid;
   assign active_src            = r_active;
   assign drop_count            = r_drop;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_interrupt_arbiter
// Directed bench for interrupt_arbiter with default parameters
// (vectors 100/200/300, DEBOUNCE_CYCLES = 16, HOLDOFF_CYCLES = 8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// Define INT_ARB_MASK_EN for both RTL and bench to exercise irq_mask.
// -----------------------------------------------------------------------------
module tb_interrupt_arbiter;

   localparam logic [31:0] INSTR_FRAME = 32'h1800_0064;
   localparam logic [31:0] INSTR_JUMP  = 32'h1800_00C8;
   localparam logic [31:0] INSTR_EXT   = 32'h1800_012C;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        frame_tick = 1'b0;
   logic        jump_key = 1'b0;
   logic        ext_req = 1'b0;
   logic        instr_ack = 1'b0;
`ifdef INT_ARB_MASK_EN
   logic [2:0]  irq_mask = 3'b000;
`endif
   logic [31:0] interrupt_instruction;
   logic        instr_valid;
   logic [1:0]  active_src;
   logic [7:0]  drop_count;

   int n_checks = 0;
   int n_errors = 0;

   interrupt_arbiter dut (
      .clock                 (clock),
      .reset                 (reset),
      .frame_tick            (frame_tick),
      .jump_key              (jump_key),
      .ext_req               (ext_req),
      .instr_ack             (instr_ack),
`ifdef INT_ARB_MASK_EN
      .irq_mask              (irq_mask),
`endif
      .interrupt_instruction (interrupt_instruction),
      .instr_valid           (instr_valid),
      .active_src            (active_src),
      .drop_count            (drop_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      frame_tick = 1'b0;
      jump_key   = 1'b0;
      ext_req    = 1'b0;
      instr_ack  = 1'b0;
      reset      = 1'b0;
      ticks(3);
      reset = 1'b1;
      tick();
   endtask

   // Hold-off: 8 clocks low after the ack edge, checked every clock.
   task automatic check_holdoff(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (instr_valid !== 1'b0) seen++;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int seen;
      int n;

      // ---- Reset, then 50 idle clocks ----------------------------------
      ticks(2);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", interrupt_instruction, 32'd0);
      check("rst_src",   32'(active_src), 32'd0);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (instr_valid !== 1'b0) seen++;
      end
      check("idle50_valid_seen", 32'(seen), 32'd0);
      check("idle50_instr", interrupt_instruction, 32'd0);
      check("idle50_drop",  32'(drop_count), 32'd0);

      // ---- Single frame tick: valid after 4th sampled edge -------------
      frame_tick = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (instr_valid !== 1'b0) seen++;
      end
      check("frame_early_valid", 32'(seen), 32'd0);
      tick();
      check("frame_valid_4th", 32'(instr_valid), 32'd1);
      check("frame_instr", interrupt_instruction, INSTR_FRAME);
      check("frame_src",   32'(active_src), 32'd1);
      frame_tick = 1'b0;
      ticks(2);
      check("frame_held_instr", interrupt_instruction, INSTR_FRAME);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      check("frame_ack_valid", 32'(instr_valid), 32'd0);
      check("frame_ack_src",   32'(active_src), 32'd0);
      check("frame_ack_instr", interrupt_instruction, 32'd0);
      check_holdoff("frame_holdoff");
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (instr_valid !== 1'b0) seen++;
      end
      check("frame_no_reissue", 32'(seen), 32'd0);

      // ---- Frame and jump pending on the same clock: frame first -------
      do_reset();
      jump_key = 1'b1;
      ticks(16);
      frame_tick = 1'b1;          // both pending bits set on the same edge
      ticks(3);
      check("pair_early_valid", 32'(instr_valid), 32'd0);
      tick();
      check("pair_first_src",   32'(active_src), 32'd1);
      check("pair_first_instr", interrupt_instruction, INSTR_FRAME);
      instr_ack = 1'b1;           // ack in the first ISSUE cycle
      tick();
      instr_ack = 1'b0;
      frame_tick = 1'b0;
      check("pair_ack_valid", 32'(instr_valid), 32'd0);
      check_holdoff("pair_holdoff");
      tick();                     // IDLE decision clock
      check("pair_second_valid", 32'(instr_valid), 32'd1);
      check("pair_second_src",   32'(active_src), 32'd2);
      check("pair_second_instr", interrupt_instruction, INSTR_JUMP);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      check("pair_second_ack_src", 32'(active_src), 32'd0);

      // ---- Bouncing jump key, then held high ---------------------------
      do_reset();
      seen = 0;
      for (int seg = 0; seg < 12; seg++) begin
         jump_key = (seg % 2 == 0);
         for (int i = 0; i < 5; i++) begin
            tick();
            if (instr_valid !== 1'b0) seen++;
         end
      end
      check("bounce_no_issue", 32'(seen), 32'd0);
      jump_key = 1'b1;
      n = 0;
      while (instr_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("bounce_latency", 32'(n), 32'd20);
      check("bounce_src",   32'(active_src), 32'd2);
      check("bounce_instr", interrupt_instruction, INSTR_JUMP);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (instr_valid !== 1'b0) seen++;
      end
      check("bounce_single_issue", 32'(seen), 32'd0);

      // ---- ext_req: 2-clock latency -----------------------------------
      do_reset();
      ext_req = 1'b1;
      tick();
      ext_req = 1'b0;
      check("ext_early_valid", 32'(instr_valid), 32'd0);
      tick();
      check("ext_valid", 32'(instr_valid), 32'd1);
      check("ext_src",   32'(active_src), 32'd3);
      check("ext_instr", interrupt_instruction, INSTR_EXT);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;

      // ---- Withheld ack: drops, coincident re-pend, reset mid-ISSUE ----
      do_reset();
      frame_tick = 1'b1;
      ticks(4);
      check("drop_issue_valid", 32'(instr_valid), 32'd1);
      frame_tick = 1'b0;
      ticks(3);
      for (int k = 0; k < 2; k++) begin
         frame_tick = 1'b1;
         ticks(3);
         frame_tick = 1'b0;
         ticks(3);
      end
      check("drop_count_2",    32'(drop_count), 32'd2);
      check("drop_held_instr", interrupt_instruction, INSTR_FRAME);
      check("drop_held_src",   32'(active_src), 32'd1);
      frame_tick = 1'b1;          // third edge: rise meets the ack's clear
      ticks(2);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      frame_tick = 1'b0;
      check("coinc_valid", 32'(instr_valid), 32'd0);
      check("coinc_drop",  32'(drop_count), 32'd2);
      check_holdoff("coinc_holdoff");
      tick();
      check("coinc_reissue_valid", 32'(instr_valid), 32'd1);
      check("coinc_reissue_src",   32'(active_src), 32'd1);
      #3;
      reset = 1'b0;               // asynchronous, between clock edges
      #1;
      check("midrst_valid", 32'(instr_valid), 32'd0);
      check("midrst_instr", interrupt_instruction, 32'd0);
      check("midrst_src",   32'(active_src), 32'd0);
      check("midrst_drop",  32'(drop_count), 32'd0);
      tick();
      reset = 1'b1;
      tick();

`ifdef INT_ARB_MASK_EN
      // ---- Mask frame: ext wins, unmask releases frame -----------------
      do_reset();
      irq_mask = 3'b001;
      frame_tick = 1'b1;
      ticks(2);
      ext_req = 1'b1;             // pends on the same edge as frame
      tick();
      ext_req = 1'b0;
      tick();
      check("mask_valid", 32'(instr_valid), 32'd1);
      check("mask_src",   32'(active_src), 32'd3);
      check("mask_instr", interrupt_instruction, INSTR_EXT);
      instr_ack = 1'b1;
      irq_mask = 3'b000;
      tick();
      instr_ack = 1'b0;
      frame_tick = 1'b0;
      check_holdoff("mask_holdoff");
      tick();
      check("unmask_src",   32'(active_src), 32'd1);
      check("unmask_instr", interrupt_instruction, INSTR_FRAME);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
